// File: rtl/control_seq_pkg.sv
// Shared definitions for the control sequencer: data width, opcodes,
// FSM state encodings and register-file write-select codes.
package control_seq_pkg;

  localparam int DATA_W = 8;

  // Instruction opcode field, IR[7:6]
  typedef enum logic [1:0] {
    OP_ALU  = 2'b00,
    OP_LDI  = 2'b01,
    OP_JMP  = 2'b10,
    OP_HALT = 2'b11
  } opcode_t;

  // Sequencer states, one 3-bit code each
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_IMM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Register-file write selects
  localparam logic [2:0] HAB_NONE = 3'b000;  // no write
  localparam logic [2:0] HAB_R0   = 3'b001;  // R0 <= ALU result
  localparam logic [2:0] HAB_R7   = 3'b011;  // R7 <= return address
  localparam logic [2:0] HAB_RX   = 3'b100;  // R[RX] <= immediate byte

endpackage

// File: rtl/cs_pc_reg.sv
// Program counter: 8-bit, wraps FF->00 silently. A jump load takes
// priority over the post-read increment (the two never coincide anyway).
module cs_pc_reg
  import control_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [DATA_W-1:0] load_value,
  output logic [DATA_W-1:0] pc
);

  // PC update: async clear, then load, then increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + 8'd1;
    end
  end

endmodule

// File: rtl/control_seq.sv
// Instruction sequencer for a tiny 8-bit machine. Fetches one byte per
// instruction (plus an immediate byte for LDI), decodes the 2-bit opcode
// and issues ALU strobes and register-file write selects. All outputs are
// registered; a read request is only raised from inside a read state, so
// the first cycle after reset and the first cycle of S_IMM are request
// setup cycles, while the S_WB -> S_FETCH edge raises the request early.
module control_seq
  import control_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] INSTR,
  input  logic              MEM_RDY,
  input  logic [DATA_W-1:0] RY_DATO,
  output logic [DATA_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  output logic [2:0]        HAB,
  output logic [2:0]        RX,
  output logic [2:0]        RY,
  output logic [DATA_W-1:0] DATO,
  output logic [DATA_W-1:0] PC_VAL,
  output logic              ALU_EN,
  output logic              HALTED
);

  state_t            state_reg;
  logic [DATA_W-1:0] ir_reg;
  logic [DATA_W-1:0] dato_reg;
  logic [DATA_W-1:0] pc_val_reg;
  logic [2:0]        hab_reg;
  logic              mem_rd_reg;
  logic              alu_en_reg;
  logic              halted_reg;

  logic [DATA_W-1:0] pc;
  logic              rd_accept;
  logic              pc_inc;
  logic              pc_load;
  opcode_t           op;

  assign op = opcode_t'(ir_reg[7:6]);

  // A read completes only when we are actually requesting; MEM_RDY alone
  // is ignored.
  assign rd_accept = mem_rd_reg && MEM_RDY;
  assign pc_inc    = rd_accept && ((state_reg == S_FETCH) || (state_reg == S_IMM));

  // The jump target is taken from RY_DATO at the S_WB edge, the same edge
  // on which the R7 return-address write lands, so RY=7 sees the old R7.
  assign pc_load   = (state_reg == S_WB) && (op == OP_JMP);

  cs_pc_reg u_pc (
    .clk        (clk),
    .reset      (reset),
    .load       (pc_load),
    .inc        (pc_inc),
    .load_value (RY_DATO),
    .pc         (pc)
  );

  // Sequencer FSM with registered outputs; strobes default low every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_FETCH;
      ir_reg     <= '0;
      dato_reg   <= '0;
      pc_val_reg <= '0;
      hab_reg    <= HAB_NONE;
      mem_rd_reg <= 1'b0;
      alu_en_reg <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      hab_reg    <= HAB_NONE;
      alu_en_reg <= 1'b0;
      case (state_reg)
        S_FETCH: begin
          if (rd_accept) begin
            ir_reg     <= INSTR;
            mem_rd_reg <= 1'b0;
            state_reg  <= S_DECODE;
          end else begin
            mem_rd_reg <= 1'b1;
          end
        end
        S_DECODE: begin
          case (op)
            OP_ALU: begin
              alu_en_reg <= 1'b1;
              state_reg  <= S_EXEC;
            end
            OP_LDI: begin
              state_reg  <= S_IMM;
            end
            OP_JMP: begin
              // PC already points past the JMP byte: that is the return address
              hab_reg    <= HAB_R7;
              pc_val_reg <= pc;
              state_reg  <= S_WB;
            end
            default: begin
              halted_reg <= 1'b1;
              state_reg  <= S_HALT;
            end
          endcase
        end
        S_EXEC: begin
          hab_reg   <= HAB_R0;
          state_reg <= S_WB;
        end
        S_IMM: begin
          if (rd_accept) begin
            dato_reg   <= INSTR;
            mem_rd_reg <= 1'b0;
            hab_reg    <= HAB_RX;
            state_reg  <= S_WB;
          end else begin
            mem_rd_reg <= 1'b1;
          end
        end
        S_WB: begin
          // Request the next instruction at once so fetch costs no setup cycle
          mem_rd_reg <= 1'b1;
          state_reg  <= S_FETCH;
        end
        S_HALT: begin
          state_reg <= S_HALT;
        end
        default: begin
          mem_rd_reg <= 1'b0;
          state_reg  <= S_FETCH;
        end
      endcase
    end
  end

  assign MEM_ADDR = pc;
  assign MEM_RD   = mem_rd_reg;
  assign HAB      = hab_reg;
  assign RX       = ir_reg[5:3];
  assign RY       = ir_reg[2:0];
  assign DATO     = dato_reg;
  assign PC_VAL   = pc_val_reg;
  assign ALU_EN   = alu_en_reg;
  assign HALTED   = halted_reg;

endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset; immediately forces the reset state of REQ-030.
REQ-003 INSTR  input  8  program-memory read data; sampled only when MEM_RDY=1.
REQ-004 MEM_RDY  input  1  program-memory handshake; INSTR is valid in the cycle MEM_RDY=1 while MEM_RD=1.
REQ-005 RY_DATO  input  8  register-file read port for R[RY]; used as the jump target.
REQ-006 MEM_ADDR  output  8  program-memory address; always equal to PC.
REQ-007 MEM_RD  output  1  program-memory read request.
REQ-008 HAB  output  3  register-file write select: 000 none, 001 R0<=RESUL, 011 R7<=PC_VAL, 100 R[RX]<=DATO.
REQ-009 RX  output  3  destination/source register index, IR[5:3].
REQ-010 RY  output  3  source register index, IR[2:0].
REQ-011 DATO  output  8  latched immediate byte for the register file.
REQ-012 PC_VAL  output  8  return address for R7.
REQ-013 ALU_EN  output  1  ALU evaluate strobe.
REQ-014 HALTED  output  1  high while in S_HALT.

Function
REQ-015 Instruction format: IR[7:6] opcode (00 ALU, 01 LDI, 10 JMP, 11 HALT); IR[5:3] RX; IR[2:0] RY.
REQ-016 States: S_FETCH, S_DECODE, S_EXEC, S_IMM, S_WB, S_HALT. Encoding: 3 bits, one code per state.
REQ-017 S_FETCH: MEM_RD=1. If MEM_RDY=0, stay. If MEM_RDY=1, IR<=INSTR, PC<=PC+1, go to S_DECODE.
REQ-018 S_DECODE transitions by opcode: ALU->S_EXEC; LDI->S_IMM; JMP->S_WB; HALT->S_HALT.
REQ-019 S_EXEC: ALU_EN=1 for exactly one cycle, then S_WB.
REQ-020 S_IMM: MEM_RD=1; wait on MEM_RDY. On MEM_RDY=1, DATO<=INSTR, PC<=PC+1, go to S_WB.
REQ-021 S_WB, one cycle, then S_FETCH:
  - ALU: HAB=001.
  - LDI: HAB=100.
  - JMP: HAB=011 with PC_VAL=PC (address after the JMP byte); PC<=RY_DATO at the same edge.
REQ-022 HAB=000, MEM_RD=0 and ALU_EN=0 in every state/cycle not listed in REQ-017..REQ-021.
REQ-023 S_HALT is absorbing: HALTED=1, no memory reads, no writes. Exit only via reset.
REQ-024 PC is 8-bit unsigned and wraps FF->00 with no flag; an LDI at FF fetches its immediate from 00.
REQ-025 Minimum latency with MEM_RDY=1: ALU 4 cycles, LDI 5, JMP 3 (fetch edge to next S_FETCH). Each MEM_RDY-low cycle adds one cycle.
REQ-026 RX and RY are driven from IR continuously; their values change only on IR load.
REQ-027 JMP with RY=7 uses the old R7 value, since RY_DATO is sampled at the S_WB edge before the R7 write lands.
REQ-028 MEM_RDY asserted while MEM_RD=0 is ignored.
REQ-029 No write enable (HAB!=000) is ever asserted in two consecutive cycles.

Reset
REQ-030 On reset=1: state=S_FETCH, PC=00, IR=00, DATO=00, HAB=000, MEM_RD=0, ALU_EN=0, HALTED=0, PC_VAL=00.
REQ-031 Reset mid-instruction (any state, including S_WB) aborts with no partial write. The first fetch after release is from address 00.
REQ-032 MEM_RD rises in the first cycle after reset deasserts.

Structure
REQ-033 Shared package holds: opcode constants, state encodings, HAB codes (HAB_NONE=000, HAB_R0=001, HAB_R7=011, HAB_RX=100) and width constant 8.
REQ-034 One sub-module, cs_pc_reg: 8-bit PC with load, increment and async reset. All other logic stays in control_seq.

Verification
REQ-035 Reset release; MEM_RDY=1; mem[00]=0x0A (ALU, RX=1, RY=2) -> ALU_EN pulse in cycle 3, HAB=001 in cycle 4, MEM_ADDR=01 in cycle 5.
REQ-036 mem[00]=0x58, mem[01]=0x3C -> DATO=3C, HAB=100, RX=3. Next fetch from 02.
REQ-037 mem[00]=0x85 (JMP RY=5), RY_DATO=0x40 -> HAB=011 with PC_VAL=01. Next MEM_ADDR=40.
REQ-038 MEM_RDY held low 3 cycles during fetch and 2 cycles during the LDI immediate -> states hold and MEM_RD stays high. Total LDI latency 10 cycles.
REQ-039 PC=FF with an LDI at FF -> immediate read from 00, next fetch from 01. mem=0xC0 -> HALTED=1, MEM_RD=0 indefinitely.
REQ-040 reset pulsed during S_WB of an ALU instruction -> HAB=000 immediately, PC=00, fetch restarts at 00.
